// File: rtl/bpu_bht.sv
// bpu_bht: PC-indexed (optionally gshare) table of saturating counters.
// Predicts in IF, carries {valid,pred,idx} through D and E, trains in E.
// Ports:
//  clk, rst (sync, active high), stall_IF/stall (freeze), flush (kill D)
//  inst/pc (IF), E_op/E_real_jump (E resolve)
//  pred_jump/pc_pred (IF), t_pnt/nt_pt (E), right_cnt/wrong_cnt (perf)
module bpu_bht #(
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int GSHARE = 0,
  parameter int GHR_W  = 4,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_IF,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       inst,
  input  logic [31:0]       pc,
  input  logic [4:0]        E_op,
  input  logic              E_real_jump,
  output logic              pred_jump,
  output logic [31:0]       pc_pred,
  output logic              t_pnt,
  output logic              nt_pt,
  output logic [PERF_W-1:0] right_cnt,
  output logic [PERF_W-1:0] wrong_cnt
);

  localparam int N = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST =
    CTR_W'((1 << (CTR_W - 1)) - 1);

  typedef struct packed {
    logic             vld;
    logic             pred;
    logic [IDX_W-1:0] idx;
  } slot_t;

  logic [CTR_W-1:0]  ctr_q [N];
  logic [CTR_W-1:0]  ctr_cur;
  logic [CTR_W-1:0]  ctr_d;
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [GHR_W:0]    ghr_sh;
  slot_t             d_q, d_d, e_q;
  logic [PERF_W-1:0] right_q, right_d;
  logic [PERF_W-1:0] wrong_q, wrong_d;

  logic             is_br;
  logic [IDX_W-1:0] pc_idx, ghr_ext, idx_if;
  logic [31:0]      b_imm;
  logic             hold, upd;
  logic             unused_inst;

  assign unused_inst = ^{inst[24:12], inst[1:0]};

  // IF: decode, index and predict
  assign is_br   = inst[6:2] == 5'b11000;
  assign pc_idx  = pc[IDX_W+1:2];
  assign ghr_ext = IDX_W'(ghr_q);
  assign idx_if  = (GSHARE != 0) ? (pc_idx ^ ghr_ext) : pc_idx;
  assign b_imm   = {{20{inst[31]}}, inst[7], inst[30:25],
                    inst[11:8], 1'b0};
  assign pc_pred   = (pc + b_imm) & ~32'd1;
  assign pred_jump = is_br & ctr_q[idx_if][CTR_W-1];

  // E: resolve
  assign hold  = stall_IF | stall;
  assign upd   = (E_op == 5'b11000) & e_q.vld;
  assign t_pnt = upd &  E_real_jump & ~e_q.pred;
  assign nt_pt = upd & ~E_real_jump &  e_q.pred;

  assign right_cnt = right_q;
  assign wrong_cnt = wrong_q;

  always_comb begin
    d_d = flush ? '0 : {is_br, pred_jump, idx_if};
  end

  // Saturating counter update for the entry held in E
  assign ctr_cur = ctr_q[e_q.idx];
  always_comb begin
    ctr_d = ctr_cur;
    if (E_real_jump) begin
      if (ctr_cur != {CTR_W{1'b1}}) ctr_d = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - CTR_W'(1);
    end
  end

  // Works for GHR_W == 1 as well: drop the oldest bit
  assign ghr_sh = {ghr_q, E_real_jump};
  assign ghr_d  = ghr_sh[GHR_W-1:0];

  always_comb begin
    right_d = right_q;
    wrong_d = wrong_q;
    if (e_q.pred == E_real_jump) begin
      if (right_q != '1) right_d = right_q + PERF_W'(1);
    end else begin
      if (wrong_q != '1) wrong_d = wrong_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= CTR_RST;
      ghr_q   <= '0;
      d_q     <= '0;
      e_q     <= '0;
      right_q <= '0;
      wrong_q <= '0;
    end else if (!hold) begin
      d_q <= d_d;
      e_q <= d_q;
      if (upd) begin
        for (int i = 0; i < N; i++)
          if (e_q.idx == IDX_W'(i)) ctr_q[i] <= ctr_d;
        ghr_q   <= ghr_d;
        right_q <= right_d;
        wrong_q <= wrong_d;
      end
    end
  end

endmodule

// File: tb/tb_bpu_bht.sv
// tb_bpu_bht: directed vectors for bpu_bht.
// Expectations queued per cycle, checked by a negedge monitor.
module tb_bpu_bht;

  localparam int M_PJ = 1;
  localparam int M_PP = 2;
  localparam int M_FL = 4;
  localparam int M_CN = 8;
  localparam int M_P1 = 16;
  localparam int M_STD = M_PJ | M_FL | M_CN;

  localparam logic [31:0] BR  = 32'h0000_0463;
  localparam logic [31:0] BN  = 32'hFE00_0FE3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 0;
  logic        rst, stall_IF, stall, flush;
  logic [31:0] inst, pc;
  logic [4:0]  E_op;
  logic        E_real_jump;

  logic        pj0, tp0, np0;
  logic [31:0] pp0;
  logic [3:0]  rc0, wc0;
  logic        pj1, tp1, np1;
  logic [31:0] pp1, rc1, wc1;

  bpu_bht #(.PERF_W(4)) u0 (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .stall(stall),
    .flush(flush), .inst(inst), .pc(pc), .E_op(E_op),
    .E_real_jump(E_real_jump), .pred_jump(pj0), .pc_pred(pp0),
    .t_pnt(tp0), .nt_pt(np0), .right_cnt(rc0), .wrong_cnt(wc0)
  );

  bpu_bht #(.GSHARE(1)) u1 (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .stall(stall),
    .flush(flush), .inst(inst), .pc(pc), .E_op(E_op),
    .E_real_jump(E_real_jump), .pred_jump(pj1), .pc_pred(pp1),
    .t_pnt(tp1), .nt_pt(np1), .right_cnt(rc1), .wrong_cnt(wc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] nm;
    int           m;
    logic         pj;
    logic [31:0]  pp;
    logic         tp;
    logic         np;
    logic [3:0]   r;
    logic [3:0]   w;
    logic         pj1;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input logic [127:0] nm, input logic [63:0] f,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s.%0s: got %h want %h", nm, f, act, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if ((e.m & M_PJ) != 0) chk(e.nm, "pj", 32'(pj0), 32'(e.pj));
      if ((e.m & M_PP) != 0) chk(e.nm, "pc_pred", pp0, e.pp);
      if ((e.m & M_FL) != 0) begin
        chk(e.nm, "t_pnt", 32'(tp0), 32'(e.tp));
        chk(e.nm, "nt_pt", 32'(np0), 32'(e.np));
      end
      if ((e.m & M_CN) != 0) begin
        chk(e.nm, "right", 32'(rc0), 32'(e.r));
        chk(e.nm, "wrong", 32'(wc0), 32'(e.w));
      end
      if ((e.m & M_P1) != 0) chk(e.nm, "pj_gs", 32'(pj1), 32'(e.pj1));
    end
  end

  task automatic drv(input logic [31:0] i_inst, input logic [31:0] i_pc,
                     input bit eb, input bit rj,
                     input logic [1:0] s, input bit f);
    inst        = i_inst;
    pc          = i_pc;
    E_op        = eb ? 5'b11000 : 5'b00000;
    E_real_jump = rj;
    stall       = s[0];
    stall_IF    = s[1];
    flush       = f;
  endtask

  task automatic step(input logic [127:0] nm, input int m,
                      input logic pj, input logic tp, input logic np,
                      input logic [3:0] r, input logic [3:0] w,
                      input logic p1, input logic [31:0] pp);
    exp_t x;
    x.nm = nm; x.m = m; x.pj = pj; x.pp = pp; x.tp = tp;
    x.np = np; x.r = r; x.w = w; x.pj1 = p1;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic ck(input logic [127:0] nm, input logic pj,
                    input logic tp, input logic np,
                    input logic [3:0] r, input logic [3:0] w);
    step(nm, M_STD, pj, tp, np, r, w, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1;
    drv(NOP, 32'h0, 0, 0, 2'b00, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // reset state and first fetch
    drv(NOP, 32'h3C, 0, 0, 2'b00, 0); ck("rst", 0, 0, 0, 0, 0);
    drv(BR,  32'h40, 0, 0, 2'b00, 0);
    step("t1", M_STD | M_PP, 0, 0, 0, 0, 0, 0, 32'h48);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t1n", 0, 0, 0, 0, 0);

    // taken training 1->2->3
    drv(BR,  32'h40, 1, 1, 2'b00, 0); ck("t2a", 0, 1, 0, 0, 0);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t2b", 0, 0, 0, 0, 1);
    drv(BR,  32'h40, 1, 1, 2'b00, 0); ck("t2c", 1, 1, 0, 0, 1);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t2d", 0, 0, 0, 0, 2);
    drv(NOP, 32'h44, 1, 1, 2'b00, 0); ck("t2e", 0, 0, 0, 0, 2);

    // saturation: five taken, then one not-taken
    drv(BR,  32'h40, 0, 0, 2'b00, 0); ck("t3a", 1, 0, 0, 1, 2);
    drv(BR,  32'h40, 0, 0, 2'b00, 0); ck("t3b", 1, 0, 0, 1, 2);
    drv(BR,  32'h40, 1, 1, 2'b00, 0); ck("t3c", 1, 0, 0, 1, 2);
    drv(BR,  32'h40, 1, 1, 2'b00, 0); ck("t3d", 1, 0, 0, 2, 2);
    drv(BR,  32'h40, 1, 1, 2'b00, 0); ck("t3e", 1, 0, 0, 3, 2);
    drv(NOP, 32'h44, 1, 1, 2'b00, 0); ck("t3f", 0, 0, 0, 4, 2);
    drv(NOP, 32'h44, 1, 1, 2'b00, 0); ck("t3g", 0, 0, 0, 5, 2);
    drv(BR,  32'h40, 0, 0, 2'b00, 0); ck("t3h", 1, 0, 0, 6, 2);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t3i", 0, 0, 0, 6, 2);
    drv(NOP, 32'h44, 1, 0, 2'b00, 0); ck("t3nt", 0, 0, 1, 6, 2);
    drv(BR,  32'h40, 0, 0, 2'b00, 0); ck("t3p", 1, 0, 0, 6, 3);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t3k", 0, 0, 0, 6, 3);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("eop", 0, 0, 0, 6, 3);

    // aliasing: 0x80 shares idx 0, 0x44 is idx 1
    drv(BR,  32'h80, 0, 0, 2'b00, 0); ck("t4a", 1, 0, 0, 6, 3);
    drv(BN,  32'h44, 0, 0, 2'b00, 0);
    step("t4b", M_STD | M_PP, 0, 0, 0, 6, 3, 0, 32'h42);
    drv(NOP, 32'h48, 0, 0, 2'b00, 0); ck("t4c", 0, 0, 0, 6, 3);
    drv(NOP, 32'h48, 0, 0, 2'b00, 0); ck("t4d", 0, 0, 0, 6, 3);

    // stall with a taken branch in E
    drv(BR,  32'h40, 0, 0, 2'b00, 0); ck("t5a", 1, 0, 0, 6, 3);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t5b", 0, 0, 0, 6, 3);
    drv(NOP, 32'h44, 1, 1, 2'b01, 0); ck("t5s1", 0, 0, 0, 6, 3);
    drv(NOP, 32'h44, 1, 1, 2'b10, 0); ck("t5s2", 0, 0, 0, 6, 3);
    drv(NOP, 32'h44, 1, 1, 2'b01, 0); ck("t5s3", 0, 0, 0, 6, 3);
    drv(NOP, 32'h44, 1, 1, 2'b00, 0); ck("t5go", 0, 0, 0, 6, 3);
    drv(BR,  32'h40, 0, 0, 2'b00, 0); ck("t5r", 1, 0, 0, 7, 3);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t5c", 0, 0, 0, 7, 3);
    drv(NOP, 32'h44, 1, 0, 2'b00, 0); ck("t5nt", 0, 0, 1, 7, 3);
    drv(BR,  32'h40, 0, 0, 2'b00, 0); ck("t5d", 1, 0, 0, 7, 4);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t5e", 0, 0, 0, 7, 4);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("t5f", 0, 0, 0, 7, 4);

    // flush kills D
    drv(BR,  32'h40, 0, 0, 2'b00, 1); ck("flA", 1, 0, 0, 7, 4);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("flB", 0, 0, 0, 7, 4);
    drv(NOP, 32'h44, 1, 0, 2'b00, 0); ck("flC", 0, 0, 0, 7, 4);
    drv(BR,  32'h40, 0, 0, 2'b00, 0); ck("flD", 1, 0, 0, 7, 4);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("flE", 0, 0, 0, 7, 4);
    // flush together with a resolve: E still trains
    drv(BR,  32'h40, 1, 1, 2'b00, 1); ck("flF", 1, 0, 0, 7, 4);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("flG", 0, 0, 0, 8, 4);
    drv(NOP, 32'h44, 1, 0, 2'b00, 0); ck("flH", 0, 0, 0, 8, 4);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("flI", 0, 0, 0, 8, 4);

    // 20 mispredicts at idx 2: counter alternates 1,2,1,...
    for (int i = 0; i < 20; i++) begin
      logic       p;
      logic [3:0] wv;
      p  = i[0];
      wv = (4 + i > 15) ? 4'hF : 4'(4 + i);
      drv(BR,  32'h48, 0, 0, 2'b00, 0);
      step("pf_f", M_PJ | M_CN, p, 0, 0, 8, wv, 0, 0);
      drv(NOP, 32'h4C, 0, 0, 2'b00, 0);
      step("pf_n", M_CN, 0, 0, 0, 8, wv, 0, 0);
      drv(NOP, 32'h50, 1, ~p, 2'b00, 0);
      step("pf_r", M_FL | M_CN, 0, ~p, p, 8, wv, 0, 0);
    end
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("pf_end", 0, 0, 0, 8, 15);

    // reset wins over stall and flush, then gshare indexing
    rst = 1;
    drv(NOP, 32'h44, 1, 1, 2'b11, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("rst2", 0, 0, 0, 0, 0);
    drv(BR,  32'h40, 0, 0, 2'b00, 0);
    step("gs1", M_PJ | M_P1, 0, 0, 0, 0, 0, 0, 0);
    drv(NOP, 32'h44, 0, 0, 2'b00, 0); ck("gs2", 0, 0, 0, 0, 0);
    drv(NOP, 32'h44, 1, 1, 2'b00, 0); ck("gs3", 0, 1, 0, 0, 0);
    drv(BR,  32'h40, 0, 0, 2'b00, 0);
    step("gs40", M_PJ | M_P1 | M_CN, 1, 0, 0, 0, 1, 0, 0);
    drv(BR,  32'h80, 0, 0, 2'b00, 0);
    step("gs80", M_PJ | M_P1, 1, 0, 0, 0, 1, 0, 0);
    drv(BR,  32'h44, 0, 0, 2'b00, 0);
    step("gs44", M_PJ | M_P1, 0, 0, 0, 0, 1, 1, 0);
    drv(NOP, 32'h48, 0, 0, 2'b00, 0); ck("gs_e", 0, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
